// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types and constants for the memory bus arbiter
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam logic [2:0] MEMOP_WORD = 3'b010;

endpackage

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port (fetch / load-store) arbiter onto a single memory bus
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_wen,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [2:0]        ls_op,
    output logic              ls_resp_valid,
    output logic [DATA_W-1:0] ls_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_op,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    owner_t            owner;
    owner_t            last_grant;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_hit;
    logic              grant_if;
    logic              grant_ls;
    logic              resp_done;
    logic              tmo;

    logic [ADDR_W-1:0] req_addr;
    logic              req_wen;
    logic [DATA_W-1:0] req_wdata;
    logic [2:0]        req_op;

    // The current REQ/WAIT cycle is the TIMEOUT-th one of this transaction.
    assign cnt_hit = (int'(cnt) + 1 >= TIMEOUT);

    assign busy          = (state != ST_IDLE);
    assign mem_req_valid = (state == ST_REQ);
    assign if_req_ready  = grant_if;
    assign ls_req_ready  = grant_ls;
    assign mem_addr      = req_addr;
    assign mem_wen       = req_wen;
    assign mem_wdata     = req_wdata;
    assign mem_op        = req_op;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round-robin grant in IDLE, bus handshake in REQ, response/timeout in WAIT.
    // A real response in the last allowed cycle wins over the timeout.
    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_ls  = 1'b0;
        resp_done = 1'b0;
        tmo       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ls_req_valid && (!if_req_valid || last_grant == OWN_IF)) begin
                    grant_ls  = 1'b1;
                    state_nxt = ST_REQ;
                end else if (if_req_valid) begin
                    grant_if  = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (cnt_hit) begin
                    tmo       = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (mem_req_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    resp_done = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cnt_hit) begin
                    tmo       = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request capture on grant, saturating busy-cycle counter, registered responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner         <= OWN_IF;
            last_grant    <= OWN_IF;
            cnt           <= '0;
            req_addr      <= '0;
            req_wen       <= 1'b0;
            req_wdata     <= '0;
            req_op        <= '0;
            if_resp_valid <= 1'b0;
            ls_resp_valid <= 1'b0;
            if_rdata      <= '0;
            ls_rdata      <= '0;
            timeout_err   <= 1'b0;
        end else begin
            if_resp_valid <= 1'b0;
            ls_resp_valid <= 1'b0;

            if (grant_ls) begin
                owner      <= OWN_LS;
                last_grant <= OWN_LS;
                cnt        <= '0;
                req_addr   <= ls_addr;
                req_wen    <= ls_wen;
                req_wdata  <= ls_wdata;
                req_op     <= ls_op;
            end else if (grant_if) begin
                owner      <= OWN_IF;
                last_grant <= OWN_IF;
                cnt        <= '0;
                req_addr   <= if_addr;
                req_wen    <= 1'b0;
                req_wdata  <= '0;
                req_op     <= MEMOP_WORD;
            end else if (busy && cnt != CNT_W'(TIMEOUT)) begin
                cnt <= cnt + 1'b1;
            end

            if (resp_done || tmo) begin
                if (owner == OWN_LS) begin
                    ls_resp_valid <= 1'b1;
                    ls_rdata      <= resp_done ? mem_rdata : '0;
                end else begin
                    if_resp_valid <= 1'b1;
                    if_rdata      <= resp_done ? mem_rdata : '0;
                end
            end

            if (tmo) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter against a transaction model
module tb_mem_bus_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req_valid = 1'b0;
    logic          if_req_ready;
    logic [AW-1:0] if_addr = '0;
    logic          if_resp_valid;
    logic [DW-1:0] if_rdata;
    logic          ls_req_valid = 1'b0;
    logic          ls_req_ready;
    logic [AW-1:0] ls_addr = '0;
    logic          ls_wen = 1'b0;
    logic [DW-1:0] ls_wdata = '0;
    logic [2:0]    ls_op = '0;
    logic          ls_resp_valid;
    logic [DW-1:0] ls_rdata;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_op;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic          timeout_err;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state: who was granted last, sticky error, last delivered data per port.
    bit            m_last_ls  = 1'b0;
    bit            m_tmo_err  = 1'b0;
    logic [DW-1:0] m_if_rdata = '0;
    logic [DW-1:0] m_ls_rdata = '0;
    bit            grant_log[$];

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_op(ls_op),
        .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_op(mem_op),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction. Memory accepts after rdy_dly stall cycles, answers after
    // rsp_dly further idle WAIT cycles; without a response the model expects a timeout
    // after exactly TMO busy cycles.
    task automatic txn(input bit rq_if, input bit rq_ls,
                       input logic [AW-1:0] a_if, input logic [AW-1:0] a_ls,
                       input logic [DW-1:0] wd, input bit we, input logic [2:0] op,
                       input int rdy_dly, input int rsp_dly, input bit give_resp,
                       input logic [DW-1:0] rd);
        bit            exp_ls;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_wen;
        logic [2:0]    e_op;
        logic [DW-1:0] e_rdata;
        int            n_busy;

        exp_ls  = rq_ls && (!rq_if || !m_last_ls);
        e_addr  = exp_ls ? a_ls : a_if;
        e_wen   = exp_ls ? we : 1'b0;
        e_wdata = exp_ls ? wd : '0;
        e_op    = exp_ls ? op : 3'b010;
        n_busy  = give_resp ? (rdy_dly + rsp_dly + 2) : TMO;
        if (n_busy > TMO) n_busy = TMO;

        @(negedge clk);
        if_req_valid = rq_if;
        ls_req_valid = rq_ls;
        if_addr = a_if; ls_addr = a_ls; ls_wdata = wd; ls_wen = we; ls_op = op;
        #1;
        chk(if_req_ready, !exp_ls, "if_req_ready_grant");
        chk(ls_req_ready, exp_ls, "ls_req_ready_grant");
        m_last_ls = exp_ls;
        grant_log.push_back(exp_ls);

        @(negedge clk);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        if_addr = $urandom; ls_addr = $urandom; ls_wdata = $urandom; ls_op = 3'($urandom);

        for (int c = 1; c <= n_busy; c++) begin
            chk(busy, 1'b1, "busy_in_txn");
            chk({if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid}, 4'b0, "quiet_during_txn");
            if (c <= rdy_dly + 1) begin
                chk(mem_req_valid, 1'b1, "mem_req_valid");
                chk(mem_addr, e_addr, "mem_addr");
                chk({mem_wen, mem_op}, {e_wen, e_op}, "mem_wen_op");
                chk(mem_wdata, e_wdata, "mem_wdata");
                mem_req_ready = (c == rdy_dly + 1);
            end else begin
                chk(mem_req_valid, 1'b0, "mem_req_valid_wait");
                mem_req_ready = 1'b0;
                mem_resp_valid = give_resp && (c == n_busy);
                mem_rdata = mem_resp_valid ? rd : DW'($urandom);
            end
            @(negedge clk);
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;

        e_rdata = give_resp ? rd : '0;
        if (!give_resp) m_tmo_err = 1'b1;
        if (exp_ls) m_ls_rdata = e_rdata; else m_if_rdata = e_rdata;
        chk(busy, 1'b0, "busy_after");
        chk({if_resp_valid, ls_resp_valid}, {!exp_ls, exp_ls}, "resp_pulse");
        chk(if_rdata, m_if_rdata, "if_rdata");
        chk(ls_rdata, m_ls_rdata, "ls_rdata");
        chk(timeout_err, m_tmo_err, "timeout_err");

        @(negedge clk);
        chk({if_resp_valid, ls_resp_valid}, 2'b00, "resp_single_pulse");
        chk(if_rdata, m_if_rdata, "if_rdata_hold");
        chk(ls_rdata, m_ls_rdata, "ls_rdata_hold");
    endtask

    initial begin
        // Reset state
        #1;
        chk({busy, mem_req_valid, if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, timeout_err},
            7'b0, "reset_ctrl");
        chk({mem_addr, mem_wdata}, 64'h0, "reset_mem_fields");
        chk({mem_wen, mem_op}, 4'b0, "reset_mem_wen_op");
        chk({if_rdata, ls_rdata}, 64'h0, "reset_rdata");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Contention right after reset: LS, IF, LS, IF
        for (int i = 0; i < 4; i++)
            txn(1, 1, $urandom, $urandom, $urandom, 1'($urandom), 3'($urandom), 0, 1, 1, $urandom);
        chk({grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 4'b1010, "contention_order");

        // Fetch only, response two cycles after acceptance
        txn(1, 0, 32'h8000_0000, '0, '0, 0, 3'b000, 0, 1, 1, 32'h0000_0413);
        chk(if_rdata, 32'h0000_0413, "fetch_rdata");

        // Store
        txn(0, 1, '0, 32'h8000_1000, 32'hDEAD_BEEF, 1, 3'b010, 0, 0, 1, $urandom);

        // Backpressure: five stall cycles before acceptance
        txn(0, 1, '0, $urandom, $urandom, 1, 3'b001, 5, 0, 1, $urandom);
        txn(1, 0, $urandom, '0, '0, 0, 3'b000, 5, 0, 1, $urandom);

        // Randomized traffic
        for (int i = 0; i < 30; i++) begin
            bit ri, rl;
            ri = 1'($urandom);
            rl = 1'($urandom);
            if (!ri && !rl) rl = 1'b1;
            txn(ri, rl, $urandom, $urandom, $urandom, 1'($urandom), 3'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), 1, $urandom);
        end

        // Timeout: accepted but never answered, and never accepted
        txn(0, 1, $urandom, $urandom, $urandom, 0, 3'b010, 0, 0, 0, '0);
        txn(1, 0, $urandom, $urandom, $urandom, 0, 3'b010, 20, 0, 0, '0);
        // Response in the very last allowed cycle still counts as data
        txn(1, 0, $urandom, '0, '0, 0, 3'b000, 2, 4, 1, 32'h1234_5678);
        txn(0, 1, $urandom, $urandom, $urandom, 0, 3'b010, 0, 1, 1, 32'hCAFE_F00D);

        // Reset while waiting for a response
        @(negedge clk);
        if_req_valid = 1'b1; if_addr = 32'h8000_0040;
        @(negedge clk);
        if_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk(busy, 1'b1, "busy_before_reset");
        rst = 1'b0;
        #1;
        chk({busy, mem_req_valid, if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, timeout_err},
            7'b0, "reset_in_wait_ctrl");
        chk({if_rdata, ls_rdata}, 64'h0, "reset_in_wait_rdata");
        chk({mem_addr, mem_wen, mem_op}, 36'h0, "reset_in_wait_mem");
        m_last_ls = 1'b0; m_tmo_err = 1'b0; m_if_rdata = '0; m_ls_rdata = '0;
        @(negedge clk);
        rst = 1'b1;
        mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk({busy, if_resp_valid, ls_resp_valid}, 3'b000, "late_resp_ignored");
            @(negedge clk);
        end
        chk(if_rdata, 32'h0, "late_resp_no_data");

        // Normal service after reset
        txn(1, 1, $urandom, $urandom, $urandom, 0, 3'b010, 1, 1, 1, $urandom);
        txn(1, 1, $urandom, $urandom, $urandom, 1, 3'b010, 0, 2, 1, $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum wait cycles for a memory response.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports named as the codebase does:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
REQ-005 SHALL have the fetch-port signals:
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted.
- if_addr  in  ADDR_W  fetch address.
- if_resp_valid  out  1  fetch data valid.
- if_rdata  out  DATA_W  fetched instruction.
REQ-006 SHALL have the load/store-port signals:
- ls_req_valid  in  1  load/store request.
- ls_req_ready  out  1  load/store request accepted.
- ls_addr  in  ADDR_W  data address.
- ls_wen  in  1  1 = store.
- ls_wdata  in  DATA_W  store data.
- ls_op  in  3  memop encoding, passed through.
- ls_resp_valid  out  1  load data valid, or store done.
- ls_rdata  out  DATA_W  load data.
REQ-007 SHALL have the memory-side signals:
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  ADDR_W  request address.
- mem_wen  out  1  request is a write.
- mem_wdata  out  DATA_W  write data.
- mem_op  out  3  memop.
- mem_resp_valid  in  1  response valid.
- mem_rdata  in  DATA_W  response data.
REQ-008 SHALL have the status signals:
- busy  out  1  transaction in flight.
- timeout_err  out  1  sticky timeout flag.

Function
REQ-009 SHALL implement the states IDLE, REQ, WAIT; it SHALL register the owner (IF or LS) and the request fields on grant.
REQ-010 In IDLE, SHALL grant when any requester is valid; it SHALL assert the selected requester's req_ready for exactly that cycle and move to REQ on the next cycle.
REQ-011 When both requesters are valid in the same IDLE cycle, SHALL grant LS unless the previous grant was LS, in which case it SHALL grant IF (round-robin; last_grant resets to IF).
REQ-012 In REQ, SHALL drive mem_req_valid=1 with the registered fields, holding them stable until mem_req_ready=1, then move to WAIT.
REQ-013 In WAIT, on mem_resp_valid=1, SHALL pulse the owner's resp_valid for one cycle with rdata equal to mem_rdata, then return to IDLE.
REQ-014 A response arriving in the same cycle as mem_req_ready (zero latency) is not allowed; the memory's response SHALL arrive at the earliest one cycle after acceptance.
REQ-015 The non-owner's req_ready and resp_valid SHALL stay 0 for the whole transaction; req_ready SHALL never be asserted outside IDLE.
REQ-016 A counter SHALL count the cycles spent in REQ plus WAIT; when it reaches TIMEOUT, the block SHALL set timeout_err=1, pulse the owner's resp_valid with rdata=0, and return to IDLE.
REQ-017 The counter SHALL clear on every grant and SHALL saturate, never wrap.
REQ-018 timeout_err SHALL be sticky until reset.
REQ-019 busy SHALL be 1 in REQ and WAIT, and 0 in IDLE.
REQ-020 if_rdata and ls_rdata SHALL be registered; each SHALL hold its last value when resp_valid=0.
REQ-021 An IF transaction SHALL drive mem_wen=0, mem_wdata=0, and mem_op=3'b010 (word).

Reset
REQ-022 On rst=0 (asynchronous), SHALL set: state=IDLE; last_grant=IF; counter=0; timeout_err=0; all valid, ready and resp outputs=0; rdata outputs=0; registered address, data and op=0.
REQ-023 A reset during REQ or WAIT SHALL abandon the transaction; no resp_valid SHALL follow the release of reset.

Structure
REQ-024 SHALL place the state enum, owner encoding and word memop constant in the shared cpu package.
REQ-025 SHALL be a single module; no sub-module is required, with the timeout counter kept inline.

Verification
REQ-026 IF only: if_addr=0x80000000, memory ready in 1 cycle, response 2 cycles later with 0x00000413 -> if_resp_valid pulses once, if_rdata=0x00000413, mem_wen=0.
REQ-027 Store: ls_addr=0x80001000, ls_wdata=0xDEADBEEF, ls_op=3'b010, ls_wen=1 -> mem fields match exactly; ls_resp_valid pulses once.
REQ-028 Contention: both requesters valid for 4 consecutive grants -> grant order LS, IF, LS, IF.
REQ-029 Backpressure: mem_req_ready held 0 for 5 cycles -> mem_addr, mem_wen and mem_wdata stay stable and no requester ready is asserted.
REQ-030 Timeout with TIMEOUT=8 and no response -> after 8 cycles timeout_err=1, owner's resp_valid pulses with rdata=0, state=IDLE; the next request is served normally.
REQ-031 Reset in WAIT: rst=0 for 1 cycle -> all outputs 0; a late mem_resp_valid is ignored (no resp_valid pulse).
